// File: rtl/mem_access_stage.sv
// MIPS memory stage: turns EX/MEM load/store controls into a req/ack bus access,
// steers byte lanes, extends load data and stalls the pipeline until completion.
module mem_access_stage #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Mem_Read_M,
    input  logic              Mem_Write_M,
    input  logic [1:0]        Mem_Size_M,
    input  logic              Mem_Unsigned_M,
    input  logic [31:0]       ALU_Result_M,
    input  logic [31:0]       Write_Data_M,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       Read_Data_M,
    output logic              Stall_M,
    output logic              Misalign_M,
    output logic              Bus_Err_M
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state, state_nxt;
    logic          access, start, tmo;
    logic [CW-1:0] cnt;
    logic [1:0]    size_q, lo_q;
    logic          uns_q;
    logic [1:0]    lo;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c, load_c;
    logic [7:0]    lb;
    logic [15:0]   lh;

    assign lo         = ALU_Result_M[1:0];
    assign access     = Mem_Read_M | Mem_Write_M;
    assign Misalign_M = access & (((Mem_Size_M == 2'b01) & lo[0]) |
                                  (Mem_Size_M[1] & (lo != 2'b00)));
    assign start      = (state == IDLE) & access & ~Misalign_M;
    assign tmo        = (state == WAIT) & ~mem_ack & (cnt == CNT_LAST);

    // Store lane steering; loads reuse the same enables so the bus sees the touched lanes.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = Write_Data_M;
        case (Mem_Size_M)
            2'b00: begin
                be_c    = 4'b0001 << lo;
                wdata_c = {4{Write_Data_M[7:0]}};
            end
            2'b01: begin
                be_c    = lo[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{Write_Data_M[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction uses the offset/size latched at request time, not the live inputs.
    always_comb begin
        lb     = 8'(mem_rdata >> {lo_q, 3'b000});
        lh     = 16'(mem_rdata >> {lo_q[1], 4'b0000});
        load_c = mem_rdata;
        case (size_q)
            2'b00:   load_c = uns_q ? {24'b0, lb} : {{24{lb[7]}}, lb};
            2'b01:   load_c = uns_q ? {16'b0, lh} : {{16{lh[15]}}, lh};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    if (mem_ack || tmo) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req = (state == WAIT);
        Stall_M = start | (state == WAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_be      <= 4'b0;
            mem_wdata   <= 32'b0;
            size_q      <= 2'b0;
            uns_q       <= 1'b0;
            lo_q        <= 2'b0;
            cnt         <= '0;
            Read_Data_M <= 32'b0;
            Bus_Err_M   <= 1'b0;
        end else begin
            Bus_Err_M <= tmo;
            if (start) begin
                mem_we    <= Mem_Write_M;
                mem_addr  <= {ALU_Result_M[ADDR_W-1:2], 2'b00};
                mem_be    <= be_c;
                mem_wdata <= wdata_c;
                size_q    <= Mem_Size_M;
                uns_q     <= Mem_Unsigned_M;
                lo_q      <= lo;
                cnt       <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if ((state == IDLE) && Misalign_M)
                Read_Data_M <= 32'b0;
            else if ((state == WAIT) && mem_ack)
                Read_Data_M <= mem_we ? 32'b0 : load_c;
            else if (tmo)
                Read_Data_M <= 32'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=8: loads, stores, lane steering,
// misalignment, timeout, late ack and asynchronous reset mid-access.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Mem_Read_M = 1'b0, Mem_Write_M = 1'b0, Mem_Unsigned_M = 1'b0;
    logic [1:0]  Mem_Size_M = 2'b00;
    logic [31:0] ALU_Result_M = '0, Write_Data_M = '0, mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_we, Stall_M, Misalign_M, Bus_Err_M;
    logic [31:0] mem_addr, mem_wdata, Read_Data_M;
    logic [3:0]  mem_be;

    int total = 0, passed = 0;

    mem_access_stage #(.TIMEOUT(8), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .Mem_Read_M(Mem_Read_M), .Mem_Write_M(Mem_Write_M), .Mem_Size_M(Mem_Size_M),
        .Mem_Unsigned_M(Mem_Unsigned_M), .ALU_Result_M(ALU_Result_M), .Write_Data_M(Write_Data_M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .Read_Data_M(Read_Data_M), .Stall_M(Stall_M), .Misalign_M(Misalign_M), .Bus_Err_M(Bus_Err_M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one access in IDLE, acks during WAIT cycle ack_at (0 = never), returns in DONE.
    task automatic do_access(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] wd, input int ack_at,
                             input logic [31:0] rdat, output int reqc, output logic [31:0] c_addr,
                             output logic [3:0] c_be, output logic [31:0] c_wd, output logic c_we,
                             output logic st_idle, output logic st_wait_ok, output logic hung);
        Mem_Read_M = rd; Mem_Write_M = wr; Mem_Size_M = sz; Mem_Unsigned_M = uns;
        ALU_Result_M = a; Write_Data_M = wd;
        #1;
        st_idle = Stall_M;
        tick();
        c_addr = mem_addr; c_be = mem_be; c_wd = mem_wdata; c_we = mem_we;
        reqc = 0; st_wait_ok = 1'b1; hung = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            if (!mem_req) begin hung = 1'b0; break; end
            reqc++;
            if (!Stall_M) st_wait_ok = 1'b0;
            if (i == ack_at) begin mem_ack = 1'b1; mem_rdata = rdat; end
            tick();
            mem_ack = 1'b0;
        end
        Mem_Read_M = 1'b0; Mem_Write_M = 1'b0;
    endtask

    int          rc;
    logic [31:0] ca, cw;
    logic [3:0]  cb;
    logic        cwe, si, swo, hg;

    initial begin
        #12;
        chk("rst_req", mem_req, 0);  chk("rst_addr", mem_addr, 0);
        chk("rst_be", mem_be, 0);    chk("rst_wdata", mem_wdata, 0);
        chk("rst_rd", Read_Data_M, 0); chk("rst_err", Bus_Err_M, 0);
        chk("rst_stall", Stall_M, 0);
        rst_n = 1'b1;
        tick();

        // LW 0x10, ack in third WAIT cycle
        do_access(1, 0, 2'b10, 0, 32'h10, 0, 3, 32'hDEADBEEF, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("lw_hang", hg, 0); chk("lw_stall_idle", si, 1); chk("lw_stall_wait", swo, 1);
        chk("lw_reqc", rc, 3); chk("lw_addr", ca, 32'h10); chk("lw_be", cb, 4'b1111);
        chk("lw_we", cwe, 0);  chk("lw_rd", Read_Data_M, 32'hDEADBEEF);
        chk("lw_done_stall", Stall_M, 0); chk("lw_done_req", mem_req, 0);
        tick();
        chk("lw_hold", Read_Data_M, 32'hDEADBEEF);

        // LB / LBU at 0x13
        do_access(1, 0, 2'b00, 0, 32'h13, 0, 1, 32'h80FF0102, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("lb_rd", Read_Data_M, 32'hFFFFFF80); chk("lb_addr", ca, 32'h10); chk("lb_be", cb, 4'b1000);
        tick();
        do_access(1, 0, 2'b00, 1, 32'h13, 0, 2, 32'h80FF0102, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("lbu_rd", Read_Data_M, 32'h00000080); chk("lbu_reqc", rc, 2);
        tick();

        // LH / LHU upper half, LH lower half positive
        do_access(1, 0, 2'b01, 0, 32'h12, 0, 1, 32'h80017FFF, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("lh_rd", Read_Data_M, 32'hFFFF8001); chk("lh_be", cb, 4'b1100);
        tick();
        do_access(1, 0, 2'b01, 0, 32'h10, 0, 1, 32'h80017FFF, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("lh_lo_rd", Read_Data_M, 32'h00007FFF); chk("lh_lo_be", cb, 4'b0011);
        tick();
        do_access(1, 0, 2'b01, 1, 32'h12, 0, 1, 32'h80017FFF, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("lhu_rd", Read_Data_M, 32'h00008001);
        tick();

        // Misaligned LW at 0x6: no request, result cleared
        Mem_Read_M = 1; Mem_Size_M = 2'b10; ALU_Result_M = 32'h6;
        #1;
        chk("mis_flag", Misalign_M, 1); chk("mis_stall", Stall_M, 0);
        tick();
        chk("mis_req", mem_req, 0); chk("mis_rd", Read_Data_M, 0);
        tick();
        chk("mis_req2", mem_req, 0);
        Mem_Read_M = 0;
        #1;
        chk("mis_noaccess", Misalign_M, 0);
        Mem_Write_M = 1; Mem_Size_M = 2'b01; ALU_Result_M = 32'h23;
        #1;
        chk("mis_sh_odd", Misalign_M, 1);
        Mem_Size_M = 2'b11; ALU_Result_M = 32'h32;
        #1;
        chk("mis_sz11", Misalign_M, 1);
        Mem_Size_M = 2'b00; ALU_Result_M = 32'h23;
        #1;
        chk("mis_sb_ok", Misalign_M, 0);
        Mem_Write_M = 0;
        tick();

        // SH 0x22, immediate ack
        do_access(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 1, 32'hFFFFFFFF, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("sh_we", cwe, 1); chk("sh_be", cb, 4'b1100); chk("sh_wd", cw, 32'hABCDABCD);
        chk("sh_addr", ca, 32'h20); chk("sh_reqc", rc, 1); chk("sh_rd", Read_Data_M, 0);
        tick();

        // SB 0x01
        do_access(0, 1, 2'b00, 0, 32'h01, 32'h123456A5, 1, 0, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("sb_be", cb, 4'b0010); chk("sb_wd", cw, 32'hA5A5A5A5); chk("sb_addr", ca, 0);
        tick();

        // Read and write both set, size 11: word write
        do_access(1, 1, 2'b11, 0, 32'h30, 32'hCAFEF00D, 2, 32'h11111111, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("sw_we", cwe, 1); chk("sw_be", cb, 4'b1111); chk("sw_wd", cw, 32'hCAFEF00D);
        chk("sw_rd", Read_Data_M, 0);
        tick();

        // Ack in the final counted cycle beats the timeout
        do_access(1, 0, 2'b10, 0, 32'h40, 0, 8, 32'h5A5A0001, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("edge_reqc", rc, 8); chk("edge_err", Bus_Err_M, 0); chk("edge_rd", Read_Data_M, 32'h5A5A0001);
        tick();

        // No ack: timeout after 8 request cycles
        do_access(1, 0, 2'b10, 0, 32'h44, 0, 0, 0, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("to_hang", hg, 0); chk("to_reqc", rc, 8); chk("to_err", Bus_Err_M, 1);
        chk("to_rd", Read_Data_M, 0); chk("to_stall", Stall_M, 0);
        tick();
        chk("to_err_pulse", Bus_Err_M, 0);
        mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_ack = 0;
        chk("late_req", mem_req, 0); chk("late_rd", Read_Data_M, 0); chk("late_err", Bus_Err_M, 0);
        tick();

        // Load a nonzero value, then reset mid-WAIT
        do_access(1, 0, 2'b10, 0, 32'h48, 0, 1, 32'h0BADF00D, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("pre_rst_rd", Read_Data_M, 32'h0BADF00D);
        tick();
        Mem_Read_M = 1; Mem_Size_M = 2'b10; ALU_Result_M = 32'h4C;
        tick();
        chk("pre_rst_req", mem_req, 1);
        #2;
        rst_n = 0; Mem_Read_M = 0;
        #1;
        chk("arst_req", mem_req, 0); chk("arst_stall", Stall_M, 0); chk("arst_rd", Read_Data_M, 0);
        tick();
        rst_n = 1;
        tick();
        chk("post_rst_req", mem_req, 0);
        do_access(1, 0, 2'b10, 0, 32'h50, 0, 2, 32'h01234567, rc, ca, cb, cw, cwe, si, swo, hg);
        chk("post_rst_rd", Read_Data_M, 32'h01234567); chk("post_rst_addr", ca, 32'h50);
        chk("post_rst_reqc", rc, 2);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
